// File: rtl/ramen_shop_ctrl_if.sv
// ramen_shop_ctrl_if
// Groups the command, response and report signals of the ramen shop order
// controller.
//   master : driven by the order front-end (commands in, status/report out)
//   slave  : used by ramen_shop_ctrl
// Command side : in_valid, op, ramen_type, portion, restock_sel,
//                restock_amt, day_end
// Response side: busy, out_valid_order, success, low_stock,
//                out_valid_tot, sold_num, total_gain
interface ramen_shop_ctrl_if #(
  parameter int CNT_W  = 7,
  parameter int GAIN_W = 16
);
  logic                   in_valid;
  logic                   op;
  logic [1:0]             ramen_type;
  logic                   portion;
  logic [2:0]             restock_sel;
  logic [15:0]            restock_amt;
  logic                   day_end;
  logic                   busy;
  logic                   out_valid_order;
  logic                   success;
  logic [4:0]             low_stock;
  logic                   out_valid_tot;
  logic [4*CNT_W-1:0]     sold_num;
  logic [GAIN_W-1:0]      total_gain;

  modport master (
    output in_valid, op, ramen_type, portion, restock_sel, restock_amt, day_end,
    input  busy, out_valid_order, success, low_stock, out_valid_tot, sold_num, total_gain
  );

  modport slave (
    input  in_valid, op, ramen_type, portion, restock_sel, restock_amt, day_end,
    output busy, out_valid_order, success, low_stock, out_valid_tot, sold_num, total_gain
  );
endinterface

// File: rtl/ramen_shop_ctrl.sv
// ramen_shop_ctrl
// Order controller for the ramen shop: checks five ingredient stocks against
// a fixed recipe table, executes orders and restocks, keeps saturating
// per-type sales counters and produces an end-of-day report, after which all
// stocks reload to their initial values.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   ctrl  : ramen_shop_ctrl_if.slave (commands in, responses/report out)
// Stock index order everywhere: 0 noodle, 1 broth, 2 tonkotsu, 3 miso, 4 soy.
module ramen_shop_ctrl #(
  parameter int CNT_W         = 7,
  parameter int GAIN_W        = 16,
  parameter int STOCK_W       = 17,
  parameter int STOCK_MAX     = 65535,
  parameter int NOODLE_INIT   = 12000,
  parameter int BROTH_INIT    = 41000,
  parameter int TONKOTSU_INIT = 9000,
  parameter int MISO_INIT     = 1000,
  parameter int SOY_INIT      = 1500
) (
  input logic             clk,
  input logic             rst_n,
  ramen_shop_ctrl_if.slave ctrl
);

  typedef enum logic {OPEN = 1'b0, REPORT = 1'b1} state_t;

  localparam logic [STOCK_W-1:0] INIT_VAL [5] = '{
    STOCK_W'(NOODLE_INIT), STOCK_W'(BROTH_INIT), STOCK_W'(TONKOTSU_INIT),
    STOCK_W'(MISO_INIT), STOCK_W'(SOY_INIT)
  };

  // Largest single-order need of each ingredient; below it an order may fail.
  localparam logic [STOCK_W-1:0] LOW_THR [5] = '{
    STOCK_W'(150), STOCK_W'(650), STOCK_W'(200), STOCK_W'(50), STOCK_W'(50)
  };

  localparam logic [STOCK_W:0] STOCK_CAP = (STOCK_W+1)'(STOCK_MAX);

  // Wide enough for the unsaturated gain and strictly wider than GAIN_W.
  localparam int FULL_W = (CNT_W + 10 > GAIN_W) ? CNT_W + 10 : GAIN_W + 1;

  state_t              state, state_next;
  logic [STOCK_W-1:0]  stock      [5];
  logic [STOCK_W-1:0]  stock_next [5];
  logic [CNT_W-1:0]    cnt        [4];
  logic [CNT_W-1:0]    cnt_next   [4];
  logic [9:0]          need       [5];
  logic                accept;
  logic                order_ok;
  logic                result;
  logic [STOCK_W:0]    restock_sum;

  logic                out_valid_order_q;
  logic                success_q;
  logic                out_valid_tot_q;
  logic [4*CNT_W-1:0]  sold_num_q;
  logic [GAIN_W-1:0]   total_gain_q;

  logic [CNT_W:0]      sum_plain, sum_soy;
  logic [FULL_W-1:0]   gain_full, gain_cap;
  logic [GAIN_W-1:0]   gain_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= OPEN;
    else        state <= state_next;
  end

  // Commands are only accepted in OPEN, so anything arriving during REPORT
  // (including at the edge that leaves it) is silently dropped.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      OPEN: begin
        accept = ctrl.in_valid;
        if (ctrl.day_end) state_next = REPORT;
      end
      REPORT:  state_next = OPEN;
      default: state_next = OPEN;
    endcase
  end

  // Recipe table: noodle/broth/tonkotsu/miso/soy per {type, portion}.
  always_comb begin
    need = '{default: '0};
    case ({ctrl.ramen_type, ctrl.portion})
      3'b000: need = '{10'd100, 10'd300, 10'd150, 10'd0,  10'd0};
      3'b001: need = '{10'd150, 10'd500, 10'd200, 10'd0,  10'd0};
      3'b010: need = '{10'd100, 10'd300, 10'd100, 10'd0,  10'd30};
      3'b011: need = '{10'd150, 10'd500, 10'd150, 10'd0,  10'd50};
      3'b100: need = '{10'd100, 10'd400, 10'd0,   10'd30, 10'd0};
      3'b101: need = '{10'd150, 10'd650, 10'd0,   10'd50, 10'd0};
      3'b110: need = '{10'd100, 10'd300, 10'd70,  10'd15, 10'd15};
      3'b111: need = '{10'd150, 10'd500, 10'd100, 10'd25, 10'd25};
      default: need = '{default: '0};
    endcase
  end

  always_comb begin
    order_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (stock[i] < STOCK_W'(need[i])) order_ok = 1'b0;
    end
  end

  // Next stock/counter values for an accepted command. Orders are all or
  // nothing; counters stick at all-ones but the order still goes through.
  always_comb begin
    stock_next  = stock;
    cnt_next    = cnt;
    result      = 1'b0;
    restock_sum = '0;
    if (accept) begin
      if (!ctrl.op) begin
        if (order_ok) begin
          for (int i = 0; i < 5; i++) stock_next[i] = stock[i] - STOCK_W'(need[i]);
          for (int t = 0; t < 4; t++) begin
            if (ctrl.ramen_type == 2'(t) && cnt[t] != {CNT_W{1'b1}})
              cnt_next[t] = cnt[t] + CNT_W'(1);
          end
          result = 1'b1;
        end
      end else begin
        for (int i = 0; i < 5; i++) begin
          if (ctrl.restock_sel == 3'(i)) begin
            restock_sum   = {1'b0, stock[i]} + (STOCK_W+1)'(ctrl.restock_amt);
            stock_next[i] = (restock_sum > STOCK_CAP) ? STOCK_W'(STOCK_MAX)
                                                      : restock_sum[STOCK_W-1:0];
            result        = 1'b1;
          end
        end
      end
    end
  end

  // Revenue at full precision, then clipped to the output width.
  always_comb begin
    sum_plain = {1'b0, cnt[0]} + {1'b0, cnt[2]};
    sum_soy   = {1'b0, cnt[1]} + {1'b0, cnt[3]};
    gain_full = FULL_W'(sum_plain) * FULL_W'(200) + FULL_W'(sum_soy) * FULL_W'(250);
    gain_cap  = {{(FULL_W-GAIN_W){1'b0}}, {GAIN_W{1'b1}}};
    gain_sat  = (gain_full > gain_cap) ? {GAIN_W{1'b1}} : gain_full[GAIN_W-1:0];
  end

  // Leaving REPORT publishes the counters for one cycle, then clears them
  // and reloads the stocks (init values are not clamped to STOCK_MAX).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stock             <= INIT_VAL;
      cnt               <= '{default: '0};
      out_valid_order_q <= 1'b0;
      success_q         <= 1'b0;
      out_valid_tot_q   <= 1'b0;
      sold_num_q        <= '0;
      total_gain_q      <= '0;
    end else begin
      out_valid_order_q <= accept;
      if (accept) success_q <= result;
      if (state == REPORT) begin
        stock           <= INIT_VAL;
        cnt             <= '{default: '0};
        out_valid_tot_q <= 1'b1;
        sold_num_q      <= {cnt[0], cnt[1], cnt[2], cnt[3]};
        total_gain_q    <= gain_sat;
      end else begin
        stock           <= stock_next;
        cnt             <= cnt_next;
        out_valid_tot_q <= 1'b0;
        sold_num_q      <= '0;
        total_gain_q    <= '0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 5; i++) ctrl.low_stock[i] = (stock[i] < LOW_THR[i]);
  end

  assign ctrl.busy            = (state == REPORT);
  assign ctrl.out_valid_order = out_valid_order_q;
  assign ctrl.success         = success_q;
  assign ctrl.out_valid_tot   = out_valid_tot_q;
  assign ctrl.sold_num        = sold_num_q;
  assign ctrl.total_gain      = total_gain_q;

endmodule

// File: tb/tb_ramen_shop_ctrl.sv
// tb_ramen_shop_ctrl
// Directed bench for ramen_shop_ctrl: a default-parameter instance for the
// order/restock/report/reset scenarios and a CNT_W=3 instance for counter
// saturation. Expected values are hand-computed from the recipe table.
module tb_ramen_shop_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ramen_shop_ctrl_if #(.CNT_W(7), .GAIN_W(16)) ctrl ();
  ramen_shop_ctrl_if #(.CNT_W(3), .GAIN_W(16)) ctrl2 ();

  ramen_shop_ctrl #(.CNT_W(7)) dut (.clk(clk), .rst_n(rst_n), .ctrl(ctrl.slave));
  ramen_shop_ctrl #(.CNT_W(3)) dut2 (.clk(clk), .rst_n(rst_n), .ctrl(ctrl2.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic op_i, input logic [1:0] type_i,
                               input logic portion_i, input logic [2:0] sel_i,
                               input logic [15:0] amt_i, input logic day_end_i);
    ctrl.in_valid    = 1'b1;
    ctrl.op          = op_i;
    ctrl.ramen_type  = type_i;
    ctrl.portion     = portion_i;
    ctrl.restock_sel = sel_i;
    ctrl.restock_amt = amt_i;
    ctrl.day_end     = day_end_i;
    tick();
    ctrl.in_valid = 1'b0;
    ctrl.day_end  = 1'b0;
  endtask

  initial begin
    ctrl.in_valid = 0; ctrl.op = 0; ctrl.ramen_type = 0; ctrl.portion = 0;
    ctrl.restock_sel = 0; ctrl.restock_amt = 0; ctrl.day_end = 0;
    ctrl2.in_valid = 0; ctrl2.op = 0; ctrl2.ramen_type = 0; ctrl2.portion = 0;
    ctrl2.restock_sel = 0; ctrl2.restock_amt = 0; ctrl2.day_end = 0;

    // Reset values
    tick(); tick();
    checkOutput("rst_busy", 64'(ctrl.busy), 0);
    checkOutput("rst_ovo", 64'(ctrl.out_valid_order), 0);
    checkOutput("rst_success", 64'(ctrl.success), 0);
    checkOutput("rst_ovt", 64'(ctrl.out_valid_tot), 0);
    checkOutput("rst_sold", 64'(ctrl.sold_num), 0);
    checkOutput("rst_gain", 64'(ctrl.total_gain), 0);
    checkOutput("rst_low", 64'(ctrl.low_stock), 0);
    checkOutput("rst_noodle", 64'(dut.stock[0]), 12000);
    rst_n = 1'b1;
    tick();

    // Single type0 large order
    applyStimulus(1'b0, 2'd0, 1'b1, 3'd0, 16'd0, 1'b0);
    checkOutput("o1_ovo", 64'(ctrl.out_valid_order), 1);
    checkOutput("o1_success", 64'(ctrl.success), 1);
    checkOutput("o1_noodle", 64'(dut.stock[0]), 11850);
    checkOutput("o1_broth", 64'(dut.stock[1]), 40500);
    checkOutput("o1_tonkotsu", 64'(dut.stock[2]), 8800);
    tick();
    checkOutput("o1_ovo_drop", 64'(ctrl.out_valid_order), 0);
    checkOutput("o1_success_hold", 64'(ctrl.success), 1);

    // Miso exhaustion: 20 back-to-back type2 large orders
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 2'd2, 1'b1, 3'd0, 16'd0, 1'b0);
      checkOutput("miso_success", 64'(ctrl.success), 1);
      checkOutput("miso_low", 64'(ctrl.low_stock), (i == 19) ? 64'd8 : 64'd0);
    end
    checkOutput("miso_zero", 64'(dut.stock[3]), 0);
    applyStimulus(1'b0, 2'd2, 1'b1, 3'd0, 16'd0, 1'b0);
    checkOutput("miso21_ovo", 64'(ctrl.out_valid_order), 1);
    checkOutput("miso21_success", 64'(ctrl.success), 0);
    checkOutput("miso21_noodle", 64'(dut.stock[0]), 8850);
    checkOutput("miso21_broth", 64'(dut.stock[1]), 27500);

    // Restocks
    applyStimulus(1'b1, 2'd0, 1'b0, 3'd4, 16'hFFFF, 1'b0);
    checkOutput("rs_soy_success", 64'(ctrl.success), 1);
    checkOutput("rs_soy_sat", 64'(dut.stock[4]), 65535);
    applyStimulus(1'b1, 2'd0, 1'b0, 3'd6, 16'd100, 1'b0);
    checkOutput("rs_bad_success", 64'(ctrl.success), 0);
    checkOutput("rs_bad_soy", 64'(dut.stock[4]), 65535);
    applyStimulus(1'b1, 2'd0, 1'b0, 3'd3, 16'd0, 1'b0);
    checkOutput("rs_zero_success", 64'(ctrl.success), 1);
    checkOutput("rs_zero_miso", 64'(dut.stock[3]), 0);
    applyStimulus(1'b1, 2'd0, 1'b0, 3'd3, 16'd200, 1'b0);
    checkOutput("rs_miso", 64'(dut.stock[3]), 200);
    checkOutput("rs_low_clear", 64'(ctrl.low_stock), 0);

    // Report with simultaneous order
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'd1, 1'b0, 3'd0, 16'd0, 1'b0);
    applyStimulus(1'b0, 2'd2, 1'b0, 3'd0, 16'd0, 1'b0);
    applyStimulus(1'b0, 2'd2, 1'b0, 3'd0, 16'd0, 1'b1);
    checkOutput("rep_busy", 64'(ctrl.busy), 1);
    checkOutput("rep_last_ovo", 64'(ctrl.out_valid_order), 1);
    checkOutput("rep_last_success", 64'(ctrl.success), 1);
    checkOutput("rep_ovt_early", 64'(ctrl.out_valid_tot), 0);
    // Order plus day_end while busy: both ignored
    applyStimulus(1'b0, 2'd0, 1'b0, 3'd0, 16'd0, 1'b1);
    checkOutput("rep_ovt", 64'(ctrl.out_valid_tot), 1);
    checkOutput("rep_sold", 64'(ctrl.sold_num), 64'({7'd0, 7'd3, 7'd2, 7'd0}));
    checkOutput("rep_gain", 64'(ctrl.total_gain), 1150);
    checkOutput("rep_busy_drop", 64'(ctrl.busy), 0);
    checkOutput("rep_dropped_ovo", 64'(ctrl.out_valid_order), 0);
    checkOutput("rep_noodle_reload", 64'(dut.stock[0]), 12000);
    checkOutput("rep_broth_reload", 64'(dut.stock[1]), 41000);
    checkOutput("rep_soy_reload", 64'(dut.stock[4]), 1500);
    tick();
    checkOutput("rep_ovt_after", 64'(ctrl.out_valid_tot), 0);
    checkOutput("rep_sold_after", 64'(ctrl.sold_num), 0);
    checkOutput("rep_gain_after", 64'(ctrl.total_gain), 0);
    ctrl.day_end = 1'b1; tick(); ctrl.day_end = 1'b0;
    checkOutput("rep2_busy", 64'(ctrl.busy), 1);
    tick();
    checkOutput("rep2_ovt", 64'(ctrl.out_valid_tot), 1);
    checkOutput("rep2_sold_cleared", 64'(ctrl.sold_num), 0);
    checkOutput("rep2_gain_cleared", 64'(ctrl.total_gain), 0);

    // Async reset during REPORT
    tick();
    applyStimulus(1'b0, 2'd0, 1'b0, 3'd0, 16'd0, 1'b0);
    ctrl.day_end = 1'b1; tick(); ctrl.day_end = 1'b0;
    checkOutput("ar_busy_before", 64'(ctrl.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ar_busy", 64'(ctrl.busy), 0);
    checkOutput("ar_success", 64'(ctrl.success), 0);
    checkOutput("ar_noodle", 64'(dut.stock[0]), 12000);
    checkOutput("ar_tonkotsu", 64'(dut.stock[2]), 9000);
    tick();
    checkOutput("ar_ovt_in_reset", 64'(ctrl.out_valid_tot), 0);
    rst_n = 1'b1;
    tick();
    checkOutput("ar_ovt_after", 64'(ctrl.out_valid_tot), 0);
    checkOutput("ar_gain_after", 64'(ctrl.total_gain), 0);

    // Counter saturation on the CNT_W=3 instance
    for (int i = 0; i < 9; i++) begin
      ctrl2.in_valid = 1'b1; ctrl2.op = 1'b0; ctrl2.ramen_type = 2'd3; ctrl2.portion = 1'b0;
      tick();
      ctrl2.in_valid = 1'b0;
      checkOutput("sat_success", 64'(ctrl2.success), 1);
    end
    checkOutput("sat_soy", 64'(dut2.stock[4]), 1365);
    ctrl2.day_end = 1'b1; tick(); ctrl2.day_end = 1'b0;
    checkOutput("sat_busy", 64'(ctrl2.busy), 1);
    tick();
    checkOutput("sat_ovt", 64'(ctrl2.out_valid_tot), 1);
    checkOutput("sat_sold", 64'(ctrl2.sold_num), 64'h007);
    checkOutput("sat_gain", 64'(ctrl2.total_gain), 1750);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
